mem_responder: RTL

Memory-side responder for the multi-cycle CPU's single-cycle memory strobes. It samples MemRead/MemWrite from the control FSM, services each request from an internal word-addressed RAM after a fixed, parameterised latency, and signals completion with a one-cycle `mem_ready` pulse. It sits between the CPU datapath (address mux, dataW, MDR) and the backing storage. It also flags illegal requests and counts strobes dropped while it is busy.

---
 rtl/mem_responder.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: services single-cycle MemRead/MemWrite strobes from an internal
// word-addressed RAM after a fixed latency, then pulses mem_ready for one cycle.
// Illegal requests (both strobes, or address beyond DEPTH) complete with err.
// Strobes that arrive while a request is in flight are counted and then discarded.
module mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] dataW,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_ready,
    output logic              busy,
    output logic              err,
    output logic [7:0]        drop_cnt
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   data_reg;
    logic                rd_reg, wr_reg;
    logic [DATA_W-1:0]   rdata_reg;
    logic                ready_reg, err_reg;
    logic [7:0]          drop_reg;

    logic                accept, commit, strobe, in_range, illegal, ram_we;
    logic [IDX_W-1:0]    rd_idx;

    logic [DATA_W-1:0]   ram [DEPTH];
    logic [DATA_W-1:0]   ram_rd_reg;

    assign strobe = MemRead | MemWrite;

    // Range check only exists when the address space is larger than the RAM.
    generate
        if (DEPTH < (2 ** ADDR_W)) begin : g_range
            assign in_range = (addr_reg < ADDR_W'(DEPTH));
        end else begin : g_full
            assign in_range = 1'b1;
        end
    endgenerate

    assign illegal = (rd_reg & wr_reg) | ~in_range;
    assign ram_we  = commit & wr_reg & ~rd_reg & in_range & ~reset;

    // In IDLE the read port follows the live address so that LATENCY=1 already
    // has the word captured by the time RESP commits; afterwards it follows the latch.
    assign rd_idx = (state_reg == IDLE) ? ADDR[IDX_W-1:0] : addr_reg[IDX_W-1:0];

    // Next-state and control decode for the request FSM.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (strobe) begin
                    accept     = 1'b1;
                    cnt_next   = CNT_W'(LATENCY - 1);
                    state_next = (LATENCY > 1) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg <= CNT_W'(1)) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                commit     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, request latch, response outputs and drop counter; reset abandons any request.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            data_reg  <= '0;
            rd_reg    <= 1'b0;
            wr_reg    <= 1'b0;
            rdata_reg <= '0;
            ready_reg <= 1'b0;
            err_reg   <= 1'b0;
            drop_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ready_reg <= commit;
            err_reg   <= commit & illegal;
            if (accept) begin
                addr_reg <= ADDR;
                data_reg <= dataW;
                rd_reg   <= MemRead;
                wr_reg   <= MemWrite;
            end
            if (commit && rd_reg && !wr_reg) begin
                rdata_reg <= in_range ? ram_rd_reg : '0;
            end
            if ((state_reg != IDLE) && strobe && (drop_reg != 8'hFF)) begin
                drop_reg <= drop_reg + 8'd1;
            end
        end
    end

    // Storage array: synchronous write on the RESP edge, registered read, no reset.
    always_ff @(posedge CLK) begin
        if (ram_we) begin
            ram[addr_reg[IDX_W-1:0]] <= data_reg;
        end
        ram_rd_reg <= ram[rd_idx];
    end

    assign rdata     = rdata_reg;
    assign mem_ready = ready_reg;
    assign err       = err_reg;
    assign busy      = (state_reg != IDLE);
    assign drop_cnt  = drop_reg;

endmodule
